// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flag_pkg
// Brief    : Shared flag indices and default vector type for the flag bank.
// Revision : 1.0 - initial release
// ============================================================================
package flag_pkg;

    localparam int FLAG_C            = 0;
    localparam int FLAG_Z            = 1;
    localparam int DEFAULT_NUM_FLAGS = 2;

    typedef logic [DEFAULT_NUM_FLAGS-1:0] flag_vec_t;

endpackage
`default_nettype wire

// File: rtl/flag_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : flag_bank_if
// Brief    : Control/status bundle between datapath control and flag bank.
// Revision : 1.0 - initial release
// ============================================================================
interface flag_bank_if #(
    parameter int NUM_FLAGS    = flag_pkg::DEFAULT_NUM_FLAGS,
    parameter int SHADOW_DEPTH = 4
);
    import flag_pkg::*;

    localparam int PTR_W = $clog2(SHADOW_DEPTH + 1);

    logic [NUM_FLAGS-1:0] din;
    logic [NUM_FLAGS-1:0] wr_en;
    logic [NUM_FLAGS-1:0] set;
    logic [NUM_FLAGS-1:0] clr;
    logic                 push;
    logic                 pop;
    logic                 err_clr;
    logic [NUM_FLAGS-1:0] flags;
    logic [PTR_W-1:0]     depth;
    logic                 shadow_full;
    logic                 shadow_empty;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output din, wr_en, set, clr, push, pop, err_clr,
        input  flags, depth, shadow_full, shadow_empty, overflow_err, underflow_err
    );

    modport slave (
        input  din, wr_en, set, clr, push, pop, err_clr,
        output flags, depth, shadow_full, shadow_empty, overflow_err, underflow_err
    );

endinterface
`default_nettype wire

// File: rtl/flag_shadow_stack.sv
`default_nettype none
// ============================================================================
// Module   : flag_shadow_stack
// Brief    : LIFO of saved flag vectors with depth pointer and sticky errors.
// Revision : 1.0 - initial release
// ============================================================================
module flag_shadow_stack #(
    parameter int NUM_FLAGS    = flag_pkg::DEFAULT_NUM_FLAGS,
    parameter int SHADOW_DEPTH = 4,
    parameter int PTR_W        = $clog2(SHADOW_DEPTH + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 i_push,
    input  wire logic                 i_pop,
    input  wire logic                 i_err_clr,
    input  wire logic [NUM_FLAGS-1:0] i_flags,
    output logic      [NUM_FLAGS-1:0] o_restore_data,
    output logic                      o_restore_valid,
    output logic      [PTR_W-1:0]     o_depth,
    output logic                      o_full,
    output logic                      o_empty,
    output logic                      o_overflow_err,
    output logic                      o_underflow_err
);
    import flag_pkg::*;

    logic [NUM_FLAGS-1:0] r_stack_q [SHADOW_DEPTH];
    logic [NUM_FLAGS-1:0] w_stack_d [SHADOW_DEPTH];
    logic [PTR_W-1:0]     r_depth_q;
    logic [PTR_W-1:0]     w_depth_d;
    logic                 r_ovf_q;
    logic                 w_ovf_d;
    logic                 r_unf_q;
    logic                 w_unf_d;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign w_full    = (r_depth_q == PTR_W'(SHADOW_DEPTH));
    assign w_empty   = (r_depth_q == '0);
    // Simultaneous push and pop cancel out: neither moves the pointer.
    assign w_push_ok = i_push && !i_pop && !w_full;
    assign w_pop_ok  = i_pop && !i_push && !w_empty;

    always_comb begin
        w_stack_d      = r_stack_q;
        o_restore_data = '0;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (w_push_ok && (r_depth_q == PTR_W'(i))) begin
                w_stack_d[i] = i_flags;
            end
            if (r_depth_q == PTR_W'(i + 1)) begin
                o_restore_data = r_stack_q[i];
            end
        end
    end

    always_comb begin
        w_depth_d = r_depth_q;
        if (w_push_ok) begin
            w_depth_d = r_depth_q + PTR_W'(1);
        end else if (w_pop_ok) begin
            w_depth_d = r_depth_q - PTR_W'(1);
        end
        // A new error in the same cycle as err_clr wins.
        w_ovf_d = (r_ovf_q && !i_err_clr) || (i_push && !i_pop && w_full);
        w_unf_d = (r_unf_q && !i_err_clr) || (i_pop && !i_push && w_empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                r_stack_q[i] <= '0;
            end
            r_depth_q <= '0;
            r_ovf_q   <= 1'b0;
            r_unf_q   <= 1'b0;
        end else begin
            r_stack_q <= w_stack_d;
            r_depth_q <= w_depth_d;
            r_ovf_q   <= w_ovf_d;
            r_unf_q   <= w_unf_d;
        end
    end

    assign o_restore_valid = w_pop_ok;
    assign o_depth         = r_depth_q;
    assign o_full          = w_full;
    assign o_empty         = w_empty;
    assign o_overflow_err  = r_ovf_q;
    assign o_underflow_err = r_unf_q;

endmodule
`default_nettype wire

// File: rtl/flag_bank.sv
`default_nettype none
// ============================================================================
// Module   : flag_bank
// Brief    : Status-flag register bank with per-bit ops and nested shadow save.
// Revision : 1.0 - initial release
// ============================================================================
module flag_bank #(
    parameter int NUM_FLAGS    = flag_pkg::DEFAULT_NUM_FLAGS,
    parameter int SHADOW_DEPTH = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    flag_bank_if.slave  bus
);
    import flag_pkg::*;

    localparam int PTR_W = $clog2(SHADOW_DEPTH + 1);

    logic [NUM_FLAGS-1:0] r_flags_q;
    logic [NUM_FLAGS-1:0] w_flags_d;
    logic [NUM_FLAGS-1:0] w_restore_data;
    logic                 w_restore_valid;
    logic [PTR_W-1:0]     w_depth;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_ovf;
    logic                 w_unf;

    flag_shadow_stack #(
        .NUM_FLAGS    (NUM_FLAGS),
        .SHADOW_DEPTH (SHADOW_DEPTH),
        .PTR_W        (PTR_W)
    ) u_shadow (
        .clk             (clk),
        .reset           (reset),
        .i_push          (bus.push),
        .i_pop           (bus.pop),
        .i_err_clr       (bus.err_clr),
        .i_flags         (r_flags_q),
        .o_restore_data  (w_restore_data),
        .o_restore_valid (w_restore_valid),
        .o_depth         (w_depth),
        .o_full          (w_full),
        .o_empty         (w_empty),
        .o_overflow_err  (w_ovf),
        .o_underflow_err (w_unf)
    );

    // A restore replaces the whole vector and discards this cycle's bit ops.
    always_comb begin
        w_flags_d = r_flags_q;
        if (w_restore_valid) begin
            w_flags_d = w_restore_data;
        end else begin
            for (int i = 0; i < NUM_FLAGS; i++) begin
                if (bus.clr[i]) begin
                    w_flags_d[i] = 1'b0;
                end else if (bus.set[i]) begin
                    w_flags_d[i] = 1'b1;
                end else if (bus.wr_en[i]) begin
                    w_flags_d[i] = bus.din[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags_q <= '0;
        end else begin
            r_flags_q <= w_flags_d;
        end
    end

    assign bus.flags         = r_flags_q;
    assign bus.depth         = w_depth;
    assign bus.shadow_full   = w_full;
    assign bus.shadow_empty  = w_empty;
    assign bus.overflow_err  = w_ovf;
    assign bus.underflow_err = w_unf;

endmodule
`default_nettype wire
